// File: rtl/cp0_regfile.sv
// MIPS32 coprocessor-0 register file: mfc0 read port, WB mtc0 commit, exception/eret capture, interrupt request.
// Optional timer (Count/Compare/TI) built only when CP0_TIMER_EN is defined.
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE = 32'h0001_8000,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay_slot,
  input  logic [31:0] exc_bad_vaddr,
  input  logic        eret_valid,
  input  logic [5:0]  hw_int,
  output logic        int_pending,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;

  logic [31:0] badvaddr;
  logic [31:0] epc;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;

  logic [31:0] count;
  logic [31:0] compare;
  logic        cause_ti;
  logic        ti_d;

  logic wr_status, wr_cause, wr_epc;

  assign wr_status = wen && (waddr == A_STATUS);
  assign wr_cause  = wen && (waddr == A_CAUSE);
  assign wr_epc    = wen && (waddr == A_EPC);

`ifdef CP0_TIMER_EN
  localparam logic DIV_LAST = (COUNT_DIV == 2);

  logic div_q;
  logic tick;
  logic wr_count, wr_compare;

  assign wr_count   = wen && (waddr == A_COUNT);
  assign wr_compare = wen && (waddr == A_COMPARE);
  assign tick       = (div_q == DIV_LAST);
  // A Compare write acknowledges the timer even if the match fires this same edge.
  assign ti_d       = wr_compare ? 1'b0 : ((count == compare) ? 1'b1 : cause_ti);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= 1'b0;
      count    <= '0;
      compare  <= '0;
      cause_ti <= 1'b0;
    end else begin
      div_q    <= tick ? 1'b0 : ~div_q;
      cause_ti <= ti_d;
      if (wr_count)
        count <= wdata;
      else if (tick)
        count <= count + 32'd1;
      if (wr_compare)
        compare <= wdata;
    end
  end
`else
  assign count    = '0;
  assign compare  = '0;
  assign cause_ti = 1'b0;
  assign ti_d     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_im  <= '0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (exc_valid) begin
      status_exl <= 1'b1;
    end else if (eret_valid) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= wdata[15:8];
      status_exl <= wdata[1];
      status_ie  <= wdata[0];
    end
  end

  // EPC/BD are frozen while already inside a handler so nested faults keep the original return point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc           <= '0;
      cause_bd      <= 1'b0;
      cause_exccode <= '0;
      cause_ip_sw   <= '0;
    end else if (exc_valid) begin
      cause_exccode <= exc_code;
      if (!status_exl) begin
        epc      <= exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
        cause_bd <= exc_in_delay_slot;
      end
    end else begin
      if (wr_epc)
        epc <= wdata;
      if (wr_cause)
        cause_ip_sw <= wdata[9:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_ip_hw <= '0;
      badvaddr    <= '0;
    end else begin
      cause_ip_hw <= {hw_int[5] | ti_d, hw_int[4:0]};
      if (exc_valid && ((exc_code == 5'd4) || (exc_code == 5'd5)))
        badvaddr <= exc_bad_vaddr;
    end
  end

  assign status_out = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_out  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw,
                       1'b0, cause_exccode, 2'b00};
  assign epc_out    = epc;

  assign int_pending = status_ie && !status_exl &&
                       (|({cause_ip_hw, cause_ip_sw} & status_im));

  // No write bypass: the downstream forwarding mux resolves same-cycle WB writes.
  always_comb begin
    rdata = '0;
    case (raddr)
      A_BADVADDR: rdata = badvaddr;
      A_COUNT:    rdata = count;
      A_COMPARE:  rdata = compare;
      A_STATUS:   rdata = status_out;
      A_CAUSE:    rdata = cause_out;
      A_EPC:      rdata = epc;
      A_PRID:     rdata = PRID_VALUE;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed test-plan steps then randomized traffic against a word-level model.
module tb_cp0_regfile;

  localparam int          COUNT_DIV = 2;
  localparam logic [31:0] PRID      = 32'h0001_8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  raddr = '0;
  logic [31:0] rdata;
  logic        wen = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_in_delay_slot = 1'b0;
  logic [31:0] exc_bad_vaddr = '0;
  logic        eret_valid = 1'b0;
  logic [5:0]  hw_int = '0;
  logic        int_pending;
  logic [31:0] status_out, cause_out, epc_out;

  cp0_regfile dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_in_delay_slot(exc_in_delay_slot), .exc_bad_vaddr(exc_bad_vaddr),
    .eret_valid(eret_valid), .hw_int(hw_int), .int_pending(int_pending),
    .status_out(status_out), .cause_out(cause_out), .epc_out(epc_out)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural state kept as whole 32-bit register images.
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
  int          m_phase;

  task automatic m_reset();
    m_status  = 32'h0040_0000;
    m_cause   = '0;
    m_epc     = '0;
    m_badv    = '0;
    m_count   = '0;
    m_compare = '0;
    m_phase   = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_irq();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h00);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".status"}, status_out, m_status);
    chk({tag, ".cause"}, cause_out, m_cause);
    chk({tag, ".epc"}, epc_out, m_epc);
    chk({tag, ".irq"}, {31'b0, int_pending}, {31'b0, m_irq()});
    chk({tag, ".rdata"}, rdata, m_read(raddr));
  endtask

  task automatic read_all(input string tag);
    logic [4:0] addrs [9] = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    logic [4:0] save = raddr;
    foreach (addrs[i]) begin
      raddr = addrs[i];
      #1;
      chk($sformatf("%s.rd%0d", tag, addrs[i]), rdata, m_read(addrs[i]));
    end
    raddr = save;
  endtask

  // Advance one clock edge: compute the model's next state from the driven inputs, then compare.
  task automatic step(input string tag);
    logic        exl, bd, ti, n_ti;
    logic [1:0]  ipsw;
    logic [4:0]  code;
    logic [31:0] n_status, n_epc, n_badv, n_count, n_compare;
    int          n_phase;
    exl = m_status[1];
    bd = m_cause[31];
    ti = m_cause[30];
    ipsw = m_cause[9:8];
    code = m_cause[6:2];
    n_status = m_status;
    n_epc = m_epc;
    n_badv = m_badv;
    n_count = m_count;
    n_compare = m_compare;
    n_phase = m_phase;
    n_ti = 1'b0;
`ifdef CP0_TIMER_EN
    if (wen && waddr == 5'd11) n_ti = 1'b0;
    else if (m_count == m_compare) n_ti = 1'b1;
    else n_ti = ti;
    if (wen && waddr == 5'd9) n_count = wdata;
    else if (m_phase == COUNT_DIV - 1) n_count = m_count + 1;
    if (wen && waddr == 5'd11) n_compare = wdata;
    n_phase = (m_phase + 1) % COUNT_DIV;
`endif
    if (exc_valid) begin
      n_status = m_status | 32'h2;
      code = exc_code;
      if (!exl) begin
        bd = exc_in_delay_slot;
        n_epc = exc_in_delay_slot ? exc_pc - 4 : exc_pc;
      end
      if (exc_code == 4 || exc_code == 5) n_badv = exc_bad_vaddr;
    end else begin
      if (eret_valid) n_status = m_status & ~32'h2;
      else if (wen && waddr == 5'd12) n_status = 32'h0040_0000 | (wdata & 32'h0000_FF03);
      if (wen && waddr == 5'd13) ipsw = wdata[9:8];
      if (wen && waddr == 5'd14) n_epc = wdata;
    end
    @(posedge clk);
    m_status = n_status;
    m_epc = n_epc;
    m_badv = n_badv;
    m_count = n_count;
    m_compare = n_compare;
    m_phase = n_phase;
    m_cause = (32'(bd) << 31) | (32'(n_ti) << 30) | (32'(hw_int[5] | n_ti) << 15) |
              (32'(hw_int[4:0]) << 10) | (32'(ipsw) << 8) | (32'(code) << 2);
    #1;
    check_outs(tag);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input string tag);
    wen = 1'b1;
    waddr = a;
    wdata = d;
    step(tag);
    wen = 1'b0;
  endtask

  initial begin
    bit seen;
    m_reset();
    #3;
    check_outs("reset_async");
    chk("reset.status_const", status_out, 32'h0040_0000);
    read_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset");
    read_all("post_reset");
    raddr = 5'd15;
    #1 chk("prid_const", rdata, 32'h0001_8000);

    mtc0(5'd12, 32'hFFFF_FFFF, "mtc0_status");
    raddr = 5'd12;
    #1 chk("status_ff_const", rdata, 32'h0040_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF, "mtc0_cause");
    raddr = 5'd13;
    #1 chk("cause_ip_sw", {22'b0, rdata[9:8], 8'b0}, 32'h0000_0300);
`ifndef CP0_TIMER_EN
    chk("cause_ff_const", rdata, 32'h0000_0300);
`endif
    mtc0(5'd12, 32'h0, "status_clear");

    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_1008;
    exc_bad_vaddr = 32'h0000_0013; exc_in_delay_slot = 1'b1;
    step("exc_ds");
    chk("exc_ds.epc_const", epc_out, 32'h0000_1004);
    chk("exc_ds.bd", {31'b0, cause_out[31]}, 32'd1);
    chk("exc_ds.code", {27'b0, cause_out[6:2]}, 32'd4);
    chk("exc_ds.exl", {31'b0, status_out[1]}, 32'd1);
    raddr = 5'd8;
    #1 chk("exc_ds.badv_const", rdata, 32'h0000_0013);

    exc_code = 5'd8; exc_pc = 32'h0000_2000; exc_in_delay_slot = 1'b0;
    step("exc_nested");
    chk("exc_nested.epc_const", epc_out, 32'h0000_1004);
    chk("exc_nested.code", {27'b0, cause_out[6:2]}, 32'd8);
    exc_valid = 1'b0;
    eret_valid = 1'b1;
    step("eret");
    chk("eret.exl", {31'b0, status_out[1]}, 32'd0);

    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_0400;
    wen = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    step("prio");
    chk("prio.epc_const", epc_out, 32'h0000_0400);
    chk("prio.exl", {31'b0, status_out[1]}, 32'd1);
    exc_valid = 1'b0; wen = 1'b0;
    step("prio_eret");
    eret_valid = 1'b0;

`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd5, "t_cmp");
    mtc0(5'd9, 32'd0, "t_cnt");
    mtc0(5'd12, 32'h0000_8001, "t_status");
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step("t_wait");
      seen = int_pending;
    end
    chk("timer_irq", {31'b0, seen}, 32'd1);
    chk("timer_ti", {31'b0, cause_out[30]}, 32'd1);
    mtc0(5'd11, 32'd100, "t_ack");
    chk("timer_ack.ti", {31'b0, cause_out[30]}, 32'd0);
    chk("timer_ack.irq", {31'b0, int_pending}, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF, "t_wrap_wr");
    step("t_wrap1");
    step("t_wrap2");
    raddr = 5'd9;
    #1 chk("timer_wrap", rdata, 32'h0);
`endif

    mtc0(5'd12, 32'h0000_0401, "im_status");
    hw_int = 6'b000001;
    #1 chk("im_before", {31'b0, int_pending}, 32'd0);
    step("im_rise");
    chk("im_rise_const", {31'b0, int_pending}, 32'd1);
    mtc0(5'd12, 32'h0000_0403, "im_exl");
    chk("im_exl_const", {31'b0, int_pending}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      wen = ($urandom_range(0, 2) == 0);
      waddr = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(8, 15));
      wdata = $urandom;
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_code = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom_range(0, 31));
      exc_pc = $urandom & 32'hFFFF_FFFC;
      exc_in_delay_slot = 1'($urandom_range(0, 1));
      exc_bad_vaddr = $urandom;
      eret_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom_range(0, 63));
      raddr = 5'($urandom_range(0, 15));
      step("rand");
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        m_reset();
        check_outs("mid_reset");
        chk("mid_reset.epc_const", epc_out, 32'h0);
        chk("mid_reset.status_const", status_out, 32'h0040_0000);
        read_all("mid_reset");
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
Coprocessor-0 register file for the MIPS32 pipeline. It supplies the raw EX-stage read value that the downstream CP0 forwarding mux selects against MEM/WB write data, and it accepts committed mtc0 writes from WB. It also captures precise exceptions and eret from the commit point and raises the interrupt request to the pipeline controller. Registers are BadVAddr, Count, Compare, Status, Cause, EPC and PRId.

Parameters:
PRID_VALUE, 32'h0001_8000, constant value returned for PRId (reg 15).
COUNT_DIV, 2, Count increments once every COUNT_DIV clock cycles (legal values 1 or 2).

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous, active-low reset
RAddr  in  5  EX-stage CP0 read address (mfc0 rd)
RData  out  32  combinational read data for RAddr; feeds the forwarding mux as its EX read input
WEn  in  1  WB-stage mtc0 commit
WAddr  in  5  WB-stage CP0 write address
WData  in  32  WB-stage CP0 write data
ExcValid  in  1  exception committed this cycle
ExcCode  in  5  exception code
ExcPC  in  32  PC of the faulting instruction
ExcInDelaySlot  in  1  faulting instruction is in a branch delay slot
ExcBadVAddr  in  32  faulting address for AdEL/AdES
EretValid  in  1  eret committed this cycle
HwInt  in  6  hardware interrupt lines, level sensitive
IntPending  out  1  interrupt request to the pipeline controller
StatusOut  out  32  current Status
CauseOut  out  32  current Cause
EPCOut  out  32  current EPC, the eret target

Behaviour:
- Reset, async on Rst_n low: Status=32'h0040_0000 (BEV=1), all other state 0, divider phase 0. Outputs follow: RData reflects the reset state, IntPending=0, EPCOut=0, CauseOut=0.
- Read: RData is purely combinational from the current registers. There is no internal write bypass; same-cycle WB writes are resolved by the downstream forwarding mux.
- Read map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRID_VALUE. Any other address reads 0.
- Write takes effect at the next edge. Writable bits:
  - Status: IM[15:8], EXL[1], IE[0]. BEV stays 1. Other bits read 0.
  - Cause: IP[9:8] only.
  - Count, Compare, EPC: all 32 bits.
  - BadVAddr, PRId and unmapped addresses: writes ignored.
- Cause layout: BD[31], TI[30], IP[15:8], ExcCode[6:2], all other bits 0.
  - IP[15:10] is registered each cycle from {HwInt[5]|TI, HwInt[4:0]}.
- Timer:
  - Divider counts 0..COUNT_DIV-1; Count increments when the divider is at COUNT_DIV-1. Count wraps from 32'hFFFF_FFFF to 0.
  - Count write beats the same-cycle increment, and the divider is not reset by the write.
  - At an edge where Count==Compare, TI is set to 1.
  - TI holds until a Compare write clears it. If a Compare write and a match occur in the same cycle, the clear wins.
- Exception (ExcValid=1):
  - If EXL=0: EPC <= ExcInDelaySlot ? ExcPC-4 : ExcPC, and BD <= ExcInDelaySlot.
  - If EXL=1: EPC and BD are unchanged.
  - Always: ExcCode <= ExcCode input, EXL <= 1.
  - If ExcCode is 4 or 5: BadVAddr <= ExcBadVAddr.
- Eret (EretValid=1, no exception): EXL <= 0.
- Same-cycle priority: ExcValid > EretValid > WEn. The lower-priority update is dropped entirely for the registers it conflicts with. An mtc0 to Count or Compare still applies during an exception or eret.
- IntPending = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]). It is combinational from the registered state.
- Reset mid-operation clears state immediately. There is no pending exception or eret memory.

Optional Feature:
CP0_TIMER_EN
- Defined: Count, Compare, the divider and TI are implemented as described above.
- Undefined:
  - The divider is removed.
  - Count and Compare read 0 and writes to them are ignored.
  - TI is constant 0, so IP7 = HwInt[5] only.
  - No timer logic is synthesised.

Test Plan:
- Reset/read map: release Rst_n and read addresses 8..15 and 3 -> Status=32'h0040_0000, PRId=32'h0001_8000, all others 0.
- mtc0 Status: write 32'hFFFF_FFFF to 12, then read 12 -> 32'h0040_FF03. Write 32'hFFFF_FFFF to 13, then read 13 -> 32'h0000_0300.
- Exception in delay slot with EXL=0: ExcCode=4, ExcPC=32'h0000_1008, ExcBadVAddr=32'h0000_0013 -> EPC=32'h0000_1004, BD=1, Cause[6:2]=4, BadVAddr=32'h13, EXL=1. A second exception (code 8, PC 32'h2000) -> EPC stays 32'h1004 and ExcCode becomes 8. Eret -> EXL=0.
- Priority: ExcValid, EretValid and WEn (addr 14, data 32'hDEAD_BEEF) all in one cycle with ExcPC=32'h400 -> EPC=32'h400 and EXL=1.
- Timer (CP0_TIMER_EN, COUNT_DIV=2): Compare=5, Count=0, Status=32'h0000_8001 -> TI=1 and IntPending=1 about 10 cycles later. Write Compare=100 -> TI=0 and IntPending=0 on the next cycle. Write Count=32'hFFFF_FFFF -> Count reads 0 two cycles later.
- Interrupt mask: HwInt=6'b000001 with IM[10]=1, IE=1 -> IntPending rises one cycle after HwInt. Set EXL=1 -> IntPending=0. Assert Rst_n low mid-run -> all registers return to reset values asynchronously.
